// File: rtl/cb_cfg_loader_if.sv
// Byte-stream configuration port: framed bytes over valid/ready plus a frame abort.
interface cb_cfg_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_abort;

  modport master (output cfg_data, output cfg_valid, output cfg_abort, input  cfg_ready);
  modport slave  (input  cfg_data, input  cfg_valid, input  cfg_abort, output cfg_ready);
endinterface

// File: rtl/cb_cfg_loader.sv
// Assembles framed configuration bytes into a 69-bit shadow word, checks the frame and
// commits it atomically to one connection-block tile (or clears every tile).
module cb_cfg_loader #(
  parameter int NUM_TILES = 4,
  parameter int PROG_W    = 69
) (
  input  logic                          clb_clk,
  input  logic                          rst,
  cb_cfg_loader_if.slave                cfg,
  output logic [NUM_TILES*PROG_W-1:0]   prog_bus,
  output logic [NUM_TILES-1:0]          tile_en,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic [1:0]                    err_code
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CSUM, S_COMMIT} state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_OP    = 2'b01;
  localparam logic [1:0] EC_ADDR  = 2'b10;
  localparam logic [1:0] EC_CSUM  = 2'b11;
  localparam logic [6:0] TILES_W  = 7'(NUM_TILES);

  state_t                        r_state;
  logic [PROG_W-1:0]             r_shadow;
  logic [3:0]                    r_cnt;
  logic [7:0]                    r_xor;
  logic [5:0]                    r_addr;
  logic                          r_op_clear;
  logic                          r_pad_bad;
  logic [NUM_TILES*PROG_W-1:0]   r_prog_bus;
  logic [NUM_TILES-1:0]          r_tile_en;
  logic                          r_done;
  logic                          r_err;
  logic [1:0]                    r_err_code;

  logic                          w_ready;
  logic                          w_accept;
  logic [1:0]                    w_hdr_op;
  logic                          w_addr_ok;

  // Ready drops combinationally on abort so an aborting cycle never also moves a byte.
  assign w_ready   = (r_state != S_COMMIT) && !cfg.cfg_abort;
  assign w_accept  = cfg.cfg_valid && w_ready;
  assign w_hdr_op  = cfg.cfg_data[7:6];
  assign w_addr_ok = {1'b0, cfg.cfg_data[5:0]} < TILES_W;

  assign cfg.cfg_ready = w_ready;
  assign prog_bus      = r_prog_bus;
  assign tile_en       = r_tile_en;
  assign cfg_busy      = (r_state != S_IDLE);
  assign cfg_done      = r_done;
  assign cfg_err       = r_err;
  assign err_code      = r_err_code;

  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tile word store is reset too, so a reset tile never sees a stale program.
      r_state    <= S_IDLE;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_xor      <= '0;
      r_addr     <= '0;
      r_op_clear <= 1'b0;
      r_pad_bad  <= 1'b0;
      r_prog_bus <= '0;
      r_tile_en  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (r_state == S_COMMIT) begin
        // The commit always completes, even with cfg_abort raised in this cycle.
        if (r_op_clear) begin
          r_prog_bus <= '0;
          r_tile_en  <= '0;
        end else begin
          for (int t = 0; t < NUM_TILES; t++) begin
            if (r_addr == 6'(t)) begin
              r_prog_bus[t*PROG_W +: PROG_W] <= r_shadow;
              r_tile_en[t]                   <= 1'b1;
            end
          end
        end
        r_done   <= 1'b1;
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (cfg.cfg_abort) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (w_accept) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_hdr_op == OP_WRITE && w_addr_ok) begin
              r_state    <= S_DATA;
              r_addr     <= cfg.cfg_data[5:0];
              r_op_clear <= 1'b0;
              r_pad_bad  <= 1'b0;
              r_xor      <= cfg.cfg_data;
              r_cnt      <= 4'd1;
              r_err_code <= EC_NONE;
            end else if (w_hdr_op == OP_WRITE) begin
              r_err_code <= EC_ADDR;
              r_err      <= 1'b1;
            end else if (w_hdr_op == OP_CLEAR) begin
              r_state    <= S_CSUM;
              r_op_clear <= 1'b1;
              r_pad_bad  <= 1'b0;
              r_xor      <= cfg.cfg_data;
              r_cnt      <= 4'd1;
              r_err_code <= EC_NONE;
            end else begin
              r_err_code <= EC_OP;
              r_err      <= 1'b1;
            end
          end
          S_DATA: begin
            for (int k = 0; k < 8; k++) begin
              if (r_cnt == 4'(k + 1)) r_shadow[8*k +: 8] <= cfg.cfg_data;
            end
            if (r_cnt == 4'd9) begin
              r_shadow[68:64] <= cfg.cfg_data[4:0];
              r_pad_bad       <= |cfg.cfg_data[7:5];
              r_state         <= S_CSUM;
            end
            r_xor <= r_xor ^ cfg.cfg_data;
            r_cnt <= r_cnt + 4'd1;
          end
          S_CSUM: begin
            if (cfg.cfg_data == r_xor && !r_pad_bad) begin
              r_state <= S_COMMIT;
            end else begin
              r_state    <= S_IDLE;
              r_cnt      <= '0;
              r_shadow   <= '0;
              r_err_code <= EC_CSUM;
              r_err      <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
